// File: rtl/fpga.sv
// -----------------------------------------------------------------------------
// fpga : shared-bus serializer for 16 nodes
//
// Each node offers a 64-bit payload, a 4-bit receiver address and a 4-bit CRC.
// A fixed-priority arbiter chooses one requesting node per frame. Node 1
// (mod[0]) has the highest priority. The chosen node's 80-bit frame is then
// shifted out on bus_show, MSB first, one bit per clock.
//
// Frame layout, bit 79 first:
//   [79]    start bit (1)
//   [78:75] sender address (node index, node1 = 0)
//   [74:71] receiver address
//   [70:7]  payload
//   [6:3]   CRC, passed through unchanged
//   [2:0]   stop bits (000)
//
// Ports:
//   clock                          system clock, rising edge
//   reset                          asynchronous, active-high reset
//   CRC1..CRC16          [3:0]     CRC field of node n
//   Data1..Data16        [63:0]    payload of node n
//   receiverAddr1..16    [3:0]     destination address of node n
//   mod                  [15:0]    request vector, bit n-1 = node n requests
//   bus_show                       registered serial bus line
// -----------------------------------------------------------------------------
module fpga #(
    parameter int NODES      = 16,
    parameter int FRAME_BITS = 80,
    parameter int DATA_W     = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        CRC1,
    input  logic [3:0]        CRC2,
    input  logic [3:0]        CRC3,
    input  logic [3:0]        CRC4,
    input  logic [3:0]        CRC5,
    input  logic [3:0]        CRC6,
    input  logic [3:0]        CRC7,
    input  logic [3:0]        CRC8,
    input  logic [3:0]        CRC9,
    input  logic [3:0]        CRC10,
    input  logic [3:0]        CRC11,
    input  logic [3:0]        CRC12,
    input  logic [3:0]        CRC13,
    input  logic [3:0]        CRC14,
    input  logic [3:0]        CRC15,
    input  logic [3:0]        CRC16,
    input  logic [DATA_W-1:0] Data1,
    input  logic [DATA_W-1:0] Data2,
    input  logic [DATA_W-1:0] Data3,
    input  logic [DATA_W-1:0] Data4,
    input  logic [DATA_W-1:0] Data5,
    input  logic [DATA_W-1:0] Data6,
    input  logic [DATA_W-1:0] Data7,
    input  logic [DATA_W-1:0] Data8,
    input  logic [DATA_W-1:0] Data9,
    input  logic [DATA_W-1:0] Data10,
    input  logic [DATA_W-1:0] Data11,
    input  logic [DATA_W-1:0] Data12,
    input  logic [DATA_W-1:0] Data13,
    input  logic [DATA_W-1:0] Data14,
    input  logic [DATA_W-1:0] Data15,
    input  logic [DATA_W-1:0] Data16,
    input  logic [3:0]        receiverAddr1,
    input  logic [3:0]        receiverAddr2,
    input  logic [3:0]        receiverAddr3,
    input  logic [3:0]        receiverAddr4,
    input  logic [3:0]        receiverAddr5,
    input  logic [3:0]        receiverAddr6,
    input  logic [3:0]        receiverAddr7,
    input  logic [3:0]        receiverAddr8,
    input  logic [3:0]        receiverAddr9,
    input  logic [3:0]        receiverAddr10,
    input  logic [3:0]        receiverAddr11,
    input  logic [3:0]        receiverAddr12,
    input  logic [3:0]        receiverAddr13,
    input  logic [3:0]        receiverAddr14,
    input  logic [3:0]        receiverAddr15,
    input  logic [3:0]        receiverAddr16,
    input  logic [15:0]       mod,
    output logic              bus_show
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_TX   = 1'b1;

    // Node inputs gathered into arrays so the granted node can be indexed.
    logic [DATA_W-1:0] data_arr [NODES];
    logic [3:0]        crc_arr  [NODES];
    logic [3:0]        addr_arr [NODES];

    assign data_arr[0]  = Data1;   assign crc_arr[0]  = CRC1;   assign addr_arr[0]  = receiverAddr1;
    assign data_arr[1]  = Data2;   assign crc_arr[1]  = CRC2;   assign addr_arr[1]  = receiverAddr2;
    assign data_arr[2]  = Data3;   assign crc_arr[2]  = CRC3;   assign addr_arr[2]  = receiverAddr3;
    assign data_arr[3]  = Data4;   assign crc_arr[3]  = CRC4;   assign addr_arr[3]  = receiverAddr4;
    assign data_arr[4]  = Data5;   assign crc_arr[4]  = CRC5;   assign addr_arr[4]  = receiverAddr5;
    assign data_arr[5]  = Data6;   assign crc_arr[5]  = CRC6;   assign addr_arr[5]  = receiverAddr6;
    assign data_arr[6]  = Data7;   assign crc_arr[6]  = CRC7;   assign addr_arr[6]  = receiverAddr7;
    assign data_arr[7]  = Data8;   assign crc_arr[7]  = CRC8;   assign addr_arr[7]  = receiverAddr8;
    assign data_arr[8]  = Data9;   assign crc_arr[8]  = CRC9;   assign addr_arr[8]  = receiverAddr9;
    assign data_arr[9]  = Data10;  assign crc_arr[9]  = CRC10;  assign addr_arr[9]  = receiverAddr10;
    assign data_arr[10] = Data11;  assign crc_arr[10] = CRC11;  assign addr_arr[10] = receiverAddr11;
    assign data_arr[11] = Data12;  assign crc_arr[11] = CRC12;  assign addr_arr[11] = receiverAddr12;
    assign data_arr[12] = Data13;  assign crc_arr[12] = CRC13;  assign addr_arr[12] = receiverAddr13;
    assign data_arr[13] = Data14;  assign crc_arr[13] = CRC14;  assign addr_arr[13] = receiverAddr14;
    assign data_arr[14] = Data15;  assign crc_arr[14] = CRC15;  assign addr_arr[14] = receiverAddr15;
    assign data_arr[15] = Data16;  assign crc_arr[15] = CRC16;  assign addr_arr[15] = receiverAddr16;

    logic [0:0]            state_q, state_d;
    logic [6:0]            cnt_q,   cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  bus_q,   bus_d;

    // Fixed priority: scan from the highest index down so that the lowest
    // set request bit is the one left in grant_idx.
    logic [3:0] grant_idx;
    always_comb begin
        grant_idx = '0;
        for (int n = NODES - 1; n >= 0; n--) begin
            if (mod[n]) begin
                grant_idx = 4'(n);
            end
        end
    end

    // Frame of the granted node; only consumed on the load edge.
    logic [FRAME_BITS-1:0] frame;
    assign frame = {1'b1, grant_idx, addr_arr[grant_idx], data_arr[grant_idx],
                    crc_arr[grant_idx], 3'b000};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bus_d   = bus_q;
        unique case (state_q)
            ST_IDLE: begin
                bus_d = 1'b0;
                if (mod != '0) begin
                    // Load edge: the frame MSB goes straight onto the line,
                    // so the counter already accounts for one bit sent.
                    shift_d = frame;
                    bus_d   = frame[FRAME_BITS-1];
                    cnt_d   = 7'd1;
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                if (cnt_q == 7'(FRAME_BITS)) begin
                    // Last bit has had its full cycle; this edge is the
                    // mandatory idle gap before the next arbitration.
                    state_d = ST_IDLE;
                    bus_d   = 1'b0;
                    cnt_d   = 7'd0;
                    shift_d = '0;
                end else begin
                    shift_d = shift_q << 1;
                    bus_d   = shift_q[FRAME_BITS-2];
                    cnt_d   = cnt_q + 7'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                bus_d   = 1'b0;
                cnt_d   = 7'd0;
                shift_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 7'd0;
            shift_q <= '0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bus_q   <= bus_d;
        end
    end

    assign bus_show = bus_q;

endmodule

// File: tb/tb_fpga.sv
module tb_fpga;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] mod;
    logic [63:0] data [16];
    logic [3:0]  crc  [16];
    logic [3:0]  addr [16];
    logic        bus_show;

    int checks = 0;
    int errors = 0;

    // Reference model state: the bit sequence still expected on the line.
    bit          exp_q[$];
    bit          exp_bit;
    bit          started;
    int          cyc = 0;
    logic [79:0] obs_frame = '0;

    localparam logic [79:0] NODE1_FRAME = 80'h8080_0000_0000_0000_0088;
    localparam logic [79:0] NODE2_FRAME = 80'h8900_0000_0000_0000_0008;

    always #5 clock = ~clock;

    fpga dut (
        .clock(clock), .reset(reset),
        .CRC1(crc[0]),   .CRC2(crc[1]),   .CRC3(crc[2]),   .CRC4(crc[3]),
        .CRC5(crc[4]),   .CRC6(crc[5]),   .CRC7(crc[6]),   .CRC8(crc[7]),
        .CRC9(crc[8]),   .CRC10(crc[9]),  .CRC11(crc[10]), .CRC12(crc[11]),
        .CRC13(crc[12]), .CRC14(crc[13]), .CRC15(crc[14]), .CRC16(crc[15]),
        .Data1(data[0]),   .Data2(data[1]),   .Data3(data[2]),   .Data4(data[3]),
        .Data5(data[4]),   .Data6(data[5]),   .Data7(data[6]),   .Data8(data[7]),
        .Data9(data[8]),   .Data10(data[9]),  .Data11(data[10]), .Data12(data[11]),
        .Data13(data[12]), .Data14(data[13]), .Data15(data[14]), .Data16(data[15]),
        .receiverAddr1(addr[0]),   .receiverAddr2(addr[1]),   .receiverAddr3(addr[2]),
        .receiverAddr4(addr[3]),   .receiverAddr5(addr[4]),   .receiverAddr6(addr[5]),
        .receiverAddr7(addr[6]),   .receiverAddr8(addr[7]),   .receiverAddr9(addr[8]),
        .receiverAddr10(addr[9]),  .receiverAddr11(addr[10]), .receiverAddr12(addr[11]),
        .receiverAddr13(addr[12]), .receiverAddr14(addr[13]), .receiverAddr15(addr[14]),
        .receiverAddr16(addr[15]),
        .mod(mod),
        .bus_show(bus_show)
    );

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_field(input logic [63:0] v, input int w);
        for (int b = w - 1; b >= 0; b--) begin
            exp_q.push_back(v[b]);
        end
    endtask

    // One clock: model acts on the inputs seen at the rising edge, the DUT
    // output is compared at the following falling edge.
    task automatic tick();
        int k;
        @(posedge clock);
        started = 1'b0;
        if (reset) begin
            exp_q.delete();
            exp_bit = 1'b0;
        end else begin
            if (exp_q.size() == 0 && mod != 16'h0) begin
                k = -1;
                for (int n = 0; n < 16; n++) begin
                    if (mod[n] && k < 0) k = n;
                end
                push_field(64'd1, 1);
                push_field(64'(k), 4);
                push_field(64'(addr[k]), 4);
                push_field(data[k], 64);
                push_field(64'(crc[k]), 4);
                push_field(64'd0, 3);
                push_field(64'd0, 1);   // idle gap after the frame
                started = 1'b1;
                $display("frame node=%0d cycle=%0d rx=%0h data=%016h crc=%0h",
                         k + 1, cyc + 1, addr[k], data[k], crc[k]);
            end
            exp_bit = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b0;
        end
        @(negedge clock);
        cyc++;
        obs_frame = {obs_frame[78:0], bus_show};
        check_eq("bus", 80'(bus_show), 80'(exp_bit));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_start();
        for (int i = 0; i < 200; i++) begin
            tick();
            if (started) return;
        end
        check_eq("start_timeout", 80'(started), 80'd1);
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_async", 80'(bus_show), 80'd0);
        exp_q.delete();
    endtask

    initial begin
        int starts[$];
        int c0;
        int r;
        reset = 1'b1;
        mod   = 16'h0;
        for (int n = 0; n < 16; n++) begin
            data[n] = '0; crc[n] = '0; addr[n] = '0;
        end
        ticks(3);
        check_eq("rst_state", 80'(bus_show), 80'd0);

        // Idle after reset with no requests.
        reset = 1'b0;
        ticks(6);
        check_eq("idle_no_req", 80'(bus_show), 80'd0);

        // Single node frame and repeat after one idle cycle.
        data[0] = 64'd1; crc[0] = 4'd1; addr[0] = 4'd1;
        mod = 16'h0001;
        wait_start();
        ticks(79);
        check_eq("node1_frame", obs_frame, NODE1_FRAME);
        tick();
        check_eq("gap", 80'(bus_show), 80'd0);
        tick();
        check_eq("repeat", 80'(started), 80'd1);

        // Switch to node 2 mid-frame; current frame must complete unchanged.
        ticks(10);
        mod = 16'h0002; data[1] = 64'd0; crc[1] = 4'd1; addr[1] = 4'd2;
        ticks(69);
        check_eq("node1_unchanged", obs_frame, NODE1_FRAME);
        wait_start();
        ticks(79);
        check_eq("node2_frame", obs_frame, NODE2_FRAME);

        // Priority: nodes 1 and 2 request, node 1 wins.
        mod = 16'h0003;
        wait_start();
        ticks(79);
        check_eq("prio_node1", obs_frame, NODE1_FRAME);

        // Node 16: sender field 1111.
        mod = 16'h8000;
        data[15] = {$urandom, $urandom}; crc[15] = 4'($urandom); addr[15] = 4'($urandom);
        wait_start();
        ticks(4);
        check_eq("node16_sender", 80'(obs_frame[4:0]), 80'h1f);
        ticks(75);

        // Input freeze: payload change mid-frame is not seen.
        mod = 16'h0001;
        wait_start();
        ticks(20);
        data[0] = '1;
        ticks(59);
        check_eq("freeze", obs_frame, NODE1_FRAME);

        // Back-to-back frames every 81 cycles.
        wait_start();
        c0 = cyc;
        for (int i = 1; i < 300; i++) begin
            tick();
            if (started) starts.push_back(cyc - c0);
        end
        check_eq("b2b_count", 80'(starts.size()), 80'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq("b2b_start", 80'((i < starts.size()) ? starts[i] : -1), 80'(81 * (i + 1)));
        end

        // Reset mid-frame aborts; no frame after release with mod=0.
        wait_start();
        ticks(30);
        async_reset();
        ticks(2);
        mod = 16'h0;
        reset = 1'b0;
        ticks(12);
        check_eq("no_resume", 80'(bus_show), 80'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                r = $urandom_range(0, 3);
                if (r == 0)      mod = 16'h0;
                else if (r == 1) mod = 16'h1 << $urandom_range(0, 15);
                else if (r == 2) mod = 16'($urandom);
            end
            r = $urandom_range(0, 15);
            data[r] = {$urandom, $urandom};
            crc[r]  = 4'($urandom);
            addr[r] = 4'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
                tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
